// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and IF/ID write side; req/ack fetch with NOP bubbles, stall hold and branch redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        nEN,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrF,
    output logic [31:0] PCplus4F,
    output logic [31:0] PCF,
    output logic        fetch_bubble
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
    state_t      state;
    logic [31:0] hold_word, redir_pc, drain_target;
    logic        valid;
    // a redirect always kills whatever word is on offer this cycle
    assign valid = !reset && !PCSrcD && (state == FETCH ? imem_ack : state == HOLD);
    assign InstrF = !valid ? NOP_WORD : state == HOLD ? hold_word : imem_rdata;
    assign fetch_bubble = !valid;
    assign imem_req = !reset && state != HOLD;
    assign imem_addr = PCF;
    assign PCplus4F = PCF + 32'd4;
    assign drain_target = PCSrcD ? PCBranchD : redir_pc;
    always_ff @(posedge CLK) begin
        if (reset) begin
            state     <= FETCH;
            PCF       <= RESET_PC;
            hold_word <= NOP_WORD;
            redir_pc  <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (PCSrcD) begin
                        if (imem_ack) PCF <= PCBranchD;
                        else begin
                            redir_pc <= PCBranchD;
                            state    <= DRAIN;
                        end
                    end else if (imem_ack && nEN) begin
                        hold_word <= imem_rdata;
                        state     <= HOLD;
                    end else if (imem_ack) PCF <= PCplus4F;
                end
                HOLD: begin
                    if (PCSrcD) begin
                        hold_word <= NOP_WORD;
                        PCF       <= PCBranchD;
                        state     <= FETCH;
                    end else if (!nEN) begin
                        PCF   <= PCplus4F;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // wrong-path request must complete before the address may move
                    redir_pc <= drain_target;
                    if (imem_ack) begin
                        PCF   <= drain_target;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios with a scoreboard of words expected to be consumed by IF/ID.
module tb_fetch_unit;
    logic        CLK = 0, reset = 1, nEN = 0, PCSrcD = 0, imem_ack = 0;
    logic [31:0] PCBranchD = 0, imem_rdata = 0;
    logic        imem_req, fetch_bubble;
    logic [31:0] imem_addr, InstrF, PCplus4F, PCF;
    int          checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    localparam logic [31:0] NOP = 32'h0000_0000;

    fetch_unit dut (
        .CLK(CLK), .reset(reset), .nEN(nEN), .PCSrcD(PCSrcD), .PCBranchD(PCBranchD),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .InstrF(InstrF), .PCplus4F(PCplus4F), .PCF(PCF), .fetch_bubble(fetch_bubble)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // every word handed to IF/ID must match the oldest expected word
    always @(negedge CLK) begin
        #2;
        if (!reset && !fetch_bubble && !nEN) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %h exp none", InstrF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (InstrF !== e) begin
                    errors++;
                    $display("FAIL sb_word got %h exp %h", InstrF, e);
                end
            end
        end
    end

    task automatic step(input logic rst, input logic nen, input logic ack, input logic src,
                        input logic [31:0] tgt);
        @(negedge CLK);
        reset = rst; nEN = nen; imem_ack = ack; PCSrcD = src; PCBranchD = tgt;
        imem_rdata = imem_addr;
        #1;
    endtask

    task automatic run_seq(input logic [31:0] from, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(from + 32'(4 * i));
            step(0, 0, 1, 0, 0);
            checks++;
            if (imem_addr !== from + 32'(4 * i) || InstrF !== imem_addr) begin
                errors++;
                $display("FAIL seq addr %h instr %h exp %h", imem_addr, InstrF, from + 32'(4 * i));
            end
        end
    endtask

    task automatic test_reset;
        step(1, 0, 1, 0, 0);
        checks++;
        if (imem_req !== 0 || InstrF !== NOP || fetch_bubble !== 1) begin
            errors++;
            $display("FAIL reset_out got req=%b instr=%h bub=%b exp 0/%h/1", imem_req, InstrF, fetch_bubble, NOP);
        end
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (PCF !== 0 || imem_req !== 1) begin
            errors++;
            $display("FAIL reset_pc got pc=%h req=%b exp 0/1", PCF, imem_req);
        end
    endtask

    task automatic test_stream;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(32'(4 * i));
            step(0, 0, 1, 0, 0);
            checks++;
            if (imem_addr !== 32'(4 * i) || InstrF !== 32'(4 * i) || PCplus4F !== 32'(4 * i + 4) || fetch_bubble !== 0) begin
                errors++;
                $display("FAIL stream addr=%h instr=%h p4=%h bub=%b exp %h", imem_addr, InstrF, PCplus4F, fetch_bubble, 32'(4 * i));
            end
        end
    endtask

    task automatic test_wait_state;
        step(1, 0, 0, 0, 0);
        run_seq(0, 4);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if (imem_addr !== 32'h10 || imem_req !== 1 || InstrF !== NOP || fetch_bubble !== 1) begin
                errors++;
                $display("FAIL wait addr=%h req=%b instr=%h bub=%b exp 10/1/NOP/1", imem_addr, imem_req, InstrF, fetch_bubble);
            end
        end
        exp_q.push_back(32'h10);
        step(0, 0, 1, 0, 0);
        checks++;
        if (InstrF !== 32'h10) begin
            errors++;
            $display("FAIL wait_ack got %h exp 00000010", InstrF);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h14) begin
            errors++;
            $display("FAIL wait_next got %h exp 00000014", imem_addr);
        end
    endtask

    task automatic test_hold;
        run_seq(32'h14, 3);
        step(0, 1, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 0, 0, 0);
            checks++;
            if (imem_req !== 0 || InstrF !== 32'h20 || fetch_bubble !== 0) begin
                errors++;
                $display("FAIL hold req=%b instr=%h bub=%b exp 0/00000020/0", imem_req, InstrF, fetch_bubble);
            end
        end
        exp_q.push_back(32'h20);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h24 || imem_req !== 1) begin
            errors++;
            $display("FAIL hold_next addr=%h req=%b exp 00000024/1", imem_addr, imem_req);
        end
    endtask

    task automatic test_drain;
        run_seq(32'h24, 3);
        step(0, 0, 0, 1, 32'h100);
        checks++;
        if (InstrF !== NOP || fetch_bubble !== 1) begin
            errors++;
            $display("FAIL drain_kill instr=%h bub=%b exp NOP/1", InstrF, fetch_bubble);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h30 || imem_req !== 1 || fetch_bubble !== 1) begin
            errors++;
            $display("FAIL drain_addr addr=%h req=%b bub=%b exp 00000030/1/1", imem_addr, imem_req, fetch_bubble);
        end
        step(0, 0, 1, 0, 0);
        checks++;
        if (InstrF !== NOP || fetch_bubble !== 1) begin
            errors++;
            $display("FAIL drain_discard instr=%h exp NOP", InstrF);
        end
        run_seq(32'h100, 1);
    endtask

    task automatic test_hold_redirect_and_reset;
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 1, 32'h200);
        checks++;
        if (InstrF !== NOP || fetch_bubble !== 1) begin
            errors++;
            $display("FAIL hold_redir instr=%h bub=%b exp NOP/1", InstrF, fetch_bubble);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h200 || imem_req !== 1) begin
            errors++;
            $display("FAIL hold_redir_addr addr=%h req=%b exp 00000200/1", imem_addr, imem_req);
        end
        step(1, 0, 1, 0, 0);
        checks++;
        if (imem_req !== 0 || fetch_bubble !== 1 || InstrF !== NOP) begin
            errors++;
            $display("FAIL midreset req=%b bub=%b instr=%h exp 0/1/NOP", imem_req, fetch_bubble, InstrF);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (PCF !== 0 || imem_addr !== 0) begin
            errors++;
            $display("FAIL midreset_pc pc=%h addr=%h exp 0", PCF, imem_addr);
        end
    endtask

    task automatic test_wrap;
        step(0, 0, 1, 1, 32'hFFFF_FFFC);
        checks++;
        if (InstrF !== NOP) begin
            errors++;
            $display("FAIL redir_ack_discard got %h exp NOP", InstrF);
        end
        exp_q.push_back(32'hFFFF_FFFC);
        step(0, 0, 1, 0, 0);
        checks++;
        if (PCF !== 32'hFFFF_FFFC || PCplus4F !== 0 || InstrF !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap pc=%h p4=%h instr=%h exp fffffffc/0/fffffffc", PCF, PCplus4F, InstrF);
        end
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 0) begin
            errors++;
            $display("FAIL wrap_next got %h exp 0", imem_addr);
        end
    endtask

    task automatic test_back_to_back;
        step(0, 0, 0, 1, 32'h40);
        step(0, 0, 0, 1, 32'h80);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (imem_addr !== 32'h80) begin
            errors++;
            $display("FAIL latest_wins got %h exp 00000080", imem_addr);
        end
        step(0, 0, 0, 1, 32'h50);
        step(0, 0, 1, 1, 32'h60);
        run_seq(32'h60, 2);
    endtask

    initial begin
        test_reset;
        test_stream;
        test_wait_state;
        test_hold;
        test_drain;
        test_hold_redirect_and_reset;
        test_wrap;
        test_back_to_back;
        step(0, 1, 0, 0, 0);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d exp 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
